// File: rtl/fft4_2d_tile_feeder.sv
// Fetches a run of 4x4 complex tiles from the image memory and streams them
// into the fft4_2d core, keeping consecutive fft_next pulses GAP cycles apart.
module fft4_2d_tile_feeder #(
  parameter int unsigned ADDR_W  = 13,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned GAP     = 1,
  localparam int unsigned TILE_W = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_tiles,
  output logic              busy,
  output logic              done,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [TILE_W-1:0] mem_rdata,
  output logic              fft_next,
  output logic [TILE_W-1:0] fft_in
);

  localparam int unsigned GAP_W = $clog2(GAP + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W-1:0]   base_nxt;
  logic [ADDR_W-1:0]   num_q;
  logic [ADDR_W-1:0]   num_nxt;
  logic [ADDR_W-1:0]   issued;
  logic [ADDR_W-1:0]   issued_nxt;
  logic [ADDR_W-1:0]   raddr_nxt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [GAP_W-1:0]    gap_nxt;
  logic [MEM_LAT:0]    vld;
  logic [MEM_LAT:0]    vld_nxt;
  logic                re_nxt;
  logic                busy_nxt;
  logic                done_nxt;

  // vld[0] is the read strobe itself; vld[MEM_LAT] marks rdata valid this cycle
  assign mem_re   = vld[0];
  assign fft_next = vld[MEM_LAT];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Reads are scheduled one cycle ahead so that mem_re/mem_raddr come straight from flops
  always_comb begin
    state_nxt  = state;
    base_nxt   = base_q;
    num_nxt    = num_q;
    issued_nxt = issued;
    gap_nxt    = gap_cnt;
    raddr_nxt  = mem_raddr;
    re_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          base_nxt   = base_addr;
          num_nxt    = num_tiles;
          issued_nxt = '0;
          if (num_tiles == '0) begin
            state_nxt = FIN;
          end else begin
            state_nxt  = ISSUE;
            re_nxt     = 1'b1;
            raddr_nxt  = base_addr;
            issued_nxt = ADDR_W'(1);
            gap_nxt    = GAP_W'(GAP - 1);
          end
        end
      end
      ISSUE: begin
        if (issued == num_q) begin
          state_nxt = DRAIN;
        end else if (gap_cnt == '0) begin
          re_nxt     = 1'b1;
          raddr_nxt  = base_q + issued;
          issued_nxt = issued + ADDR_W'(1);
          gap_nxt    = GAP_W'(GAP - 1);
        end else begin
          gap_nxt = gap_cnt - GAP_W'(1);
        end
      end
      DRAIN: begin
        if (vld == '0) state_nxt = FIN;
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    vld_nxt  = {vld[MEM_LAT-1:0], re_nxt};
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == FIN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_q    <= '0;
      num_q     <= '0;
      issued    <= '0;
      gap_cnt   <= '0;
      vld       <= '0;
      mem_raddr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fft_in    <= '0;
    end else begin
      base_q    <= base_nxt;
      num_q     <= num_nxt;
      issued    <= issued_nxt;
      gap_cnt   <= gap_nxt;
      vld       <= vld_nxt;
      mem_raddr <= raddr_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      if (vld[MEM_LAT]) fft_in <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_fft4_2d_tile_feeder.sv
// Bench for fft4_2d_tile_feeder: two instances (MEM_LAT/GAP = 1/1 and 2/3) share
// stimulus and are checked every cycle against a timeline model of each run.
module tb_fft4_2d_tile_feeder;

  localparam int unsigned AW = 13;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] num;
    int            exp_reads;
    logic [AW-1:0] exp_last;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] num_tiles;

  logic          busy_o  [2];
  logic          done_o  [2];
  logic          re_o    [2];
  logic          next_o  [2];
  logic [AW-1:0] raddr_o [2];
  logic [1023:0] rdata   [2];
  logic [1023:0] fin_o   [2];

  logic [AW-1:0] ap0;
  logic [AW-1:0] ap1a;
  logic [AW-1:0] ap1b;
  logic [31:0]   seed;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int cnt_re   [2];
  int cnt_next [2];
  int cnt_done [2];

  logic          m_act  [2];
  int            m_t0   [2];
  logic [AW-1:0] m_base [2];
  int            m_num  [2];
  logic [AW-1:0] e_addr [2];
  logic [1023:0] e_tile [2];
  logic          e_re, e_next, e_busy, e_done;
  int            mi;

  always #5 clk = ~clk;

  fft4_2d_tile_feeder #(.ADDR_W(AW), .MEM_LAT(1), .GAP(1)) u_dut_a (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_tiles(num_tiles),
    .busy(busy_o[0]), .done(done_o[0]), .mem_re(re_o[0]), .mem_raddr(raddr_o[0]),
    .mem_rdata(rdata[0]), .fft_next(next_o[0]), .fft_in(fin_o[0])
  );

  fft4_2d_tile_feeder #(.ADDR_W(AW), .MEM_LAT(2), .GAP(3)) u_dut_b (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_tiles(num_tiles),
    .busy(busy_o[1]), .done(done_o[1]), .mem_re(re_o[1]), .mem_raddr(raddr_o[1]),
    .mem_rdata(rdata[1]), .fft_next(next_o[1]), .fft_in(fin_o[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic int gap_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Pseudo-random but address-unique tile contents
  function automatic logic [1023:0] tile(input logic [AW-1:0] a, input logic [31:0] s);
    logic [1023:0] t;
    logic [31:0]   w;
    t = '0;
    for (int k = 0; k < 32; k++) begin
      w = ({19'd0, a} * 32'h9E3779B1) ^ (32'(k) * 32'h85EBCA77) ^ s;
      w = w ^ (w >> 15);
      w = w * 32'h2C1B3C6D;
      w = w ^ (w >> 12);
      t[k*32 +: 32] = w;
    end
    return t;
  endfunction

  // Index of the tile whose event falls 'off' cycles into a run, or -1
  function automatic int hit(input int off, input int g, input int n);
    if (off < 0 || (off % g) != 0 || (off / g) >= n) return -1;
    return off / g;
  endfunction

  function automatic int t_done(input int d);
    if (m_num[d] == 0) return m_t0[d] + 1;
    return m_t0[d] + 1 + (m_num[d] - 1) * gap_of(d) + lat_of(d) + 2;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] cycle %0d: got %h expected %h", name, d, cyc, act, exp);
    end
  endtask

  task automatic chk_tile(input int d, input logic [1023:0] act, input logic [1023:0] exp);
    int w;
    w = 0;
    n_cmp++;
    if (act !== exp) begin
      for (int k = 31; k >= 0; k--) if (act[k*32 +: 32] !== exp[k*32 +: 32]) w = k;
      n_bad++;
      $display("FAIL fft_in[%0d] cycle %0d word %0d: got %h expected %h",
               d, cyc, w, act[w*32 +: 32], exp[w*32 +: 32]);
    end
  endtask

  // Memory model: data for the address presented MEM_LAT cycles earlier
  assign rdata[0] = tile(ap0, seed);
  assign rdata[1] = tile(ap1b, seed);

  always @(posedge clk) begin
    ap0  <= raddr_o[0];
    ap1a <= raddr_o[1];
    ap1b <= ap1a;
  end

  // Model: start acceptance only outside a run's busy window
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset && start && !(m_act[d] && cyc <= t_done(d))) begin
        m_act[d]  = 1'b1;
        m_t0[d]   = cyc;
        m_base[d] = base_addr;
        m_num[d]  = int'(num_tiles);
      end
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      e_re = 1'b0; e_next = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      if (!reset) begin
        m_act[d]  = 1'b0;
        e_addr[d] = '0;
        e_tile[d] = '0;
      end else if (m_act[d]) begin
        mi = hit(cyc - m_t0[d] - 1, gap_of(d), m_num[d]);
        if (mi >= 0) begin
          e_re      = 1'b1;
          e_addr[d] = m_base[d] + AW'(mi);
        end
        e_next = (hit(cyc - m_t0[d] - 1 - lat_of(d), gap_of(d), m_num[d]) >= 0);
        mi = hit(cyc - m_t0[d] - 2 - lat_of(d), gap_of(d), m_num[d]);
        if (mi >= 0) e_tile[d] = tile(m_base[d] + AW'(mi), seed);
        e_busy = (cyc > m_t0[d]) && (cyc <= t_done(d));
        e_done = (cyc == t_done(d));
      end
      chk("busy", d, 32'(busy_o[d]), 32'(e_busy));
      chk("done", d, 32'(done_o[d]), 32'(e_done));
      chk("mem_re", d, 32'(re_o[d]), 32'(e_re));
      chk("mem_raddr", d, 32'(raddr_o[d]), 32'(e_addr[d]));
      chk("fft_next", d, 32'(next_o[d]), 32'(e_next));
      chk_tile(d, fin_o[d], e_tile[d]);
      if (re_o[d] === 1'b1)   cnt_re[d]++;
      if (next_o[d] === 1'b1) cnt_next[d]++;
      if (done_o[d] === 1'b1) cnt_done[d]++;
    end
  end

  task automatic clr_cnt();
    for (int d = 0; d < 2; d++) begin
      cnt_re[d] = 0; cnt_next[d] = 0; cnt_done[d] = 0;
    end
  endtask

  task automatic wait_idle(input int max_cyc);
    n_cmp++;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk); #1;
      if (busy_o[0] === 1'b0 && busy_o[1] === 1'b0) return;
    end
    n_bad++;
    $display("FAIL wait_idle: still busy after %0d cycles (busy %b %b)", max_cyc, busy_o[0], busy_o[1]);
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input logic [AW-1:0] n);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; num_tiles = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic chk_async_zero();
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", d, 32'(busy_o[d]), 32'd0);
      chk("rst_done", d, 32'(done_o[d]), 32'd0);
      chk("rst_re", d, 32'(re_o[d]), 32'd0);
      chk("rst_next", d, 32'(next_o[d]), 32'd0);
      chk("rst_raddr", d, 32'(raddr_o[d]), 32'd0);
      chk_tile(d, fin_o[d], '0);
    end
  endtask

  initial begin
    vec_t vecs[6];
    bit   got;
    vecs[0] = '{13'h0010, 13'd4, 4, 13'h0013};
    vecs[1] = '{13'h0040, 13'd3, 3, 13'h0042};
    vecs[2] = '{13'h1FFE, 13'd3, 3, 13'h0000};
    vecs[3] = '{13'h0ABC, 13'd0, 0, 13'h0000};
    vecs[4] = '{13'h0ABC, 13'd1, 1, 13'h0ABC};
    vecs[5] = '{13'h1FFF, 13'd2, 2, 13'h0000};

    seed = $urandom;
    for (int d = 0; d < 2; d++) m_act[d] = 1'b0;
    clr_cnt();
    reset = 1'b1; start = 1'b0; base_addr = '0; num_tiles = '0;
    #1 reset = 1'b0;

    // Reset held with start toggling, then idle after release
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      start = ~start; base_addr = AW'($urandom); num_tiles = AW'(3);
    end
    start = 1'b0;
    @(negedge clk); #1 reset = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      clr_cnt();
      pulse_start(vecs[i].base, vecs[i].num);
      wait_idle(200);
      for (int d = 0; d < 2; d++) begin
        chk("vec_reads", d, 32'(cnt_re[d]), 32'(vecs[i].exp_reads));
        chk("vec_nexts", d, 32'(cnt_next[d]), 32'(vecs[i].exp_reads));
        chk("vec_dones", d, 32'(cnt_done[d]), 32'd1);
        chk("vec_last_addr", d, 32'(raddr_o[d]), 32'(vecs[i].exp_last));
      end
    end

    // Second start with a different base while busy
    clr_cnt();
    pulse_start(13'h0200, 13'd8);
    repeat (2) @(posedge clk);
    #1 start = 1'b1; base_addr = 13'h0400; num_tiles = 13'd5;
    @(posedge clk); #1 start = 1'b0;
    wait_idle(200);
    for (int d = 0; d < 2; d++) begin
      chk("busy_start_reads", d, 32'(cnt_re[d]), 32'd8);
      chk("busy_start_dones", d, 32'(cnt_done[d]), 32'd1);
      chk("busy_start_last", d, 32'(raddr_o[d]), 32'h0207);
    end

    // Start in the done cycle is ignored, the following IDLE cycle is accepted
    pulse_start(13'h0300, 13'd2);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk); #1;
      if (done_o[1] === 1'b1) got = 1'b1;
    end
    chk("wait_done_b", 1, 32'(got), 32'd1);
    start = 1'b1; base_addr = 13'h0310; num_tiles = 13'd1;
    @(negedge clk); #1;
    chk("start_at_done_ignored", 1, 32'(busy_o[1]), 32'd0);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk); #1;
    chk("start_after_done_taken", 1, 32'(busy_o[1]), 32'd1);
    wait_idle(200);

    // Reset after two reads of an eight-tile run
    clr_cnt();
    pulse_start(13'h0500, 13'd8);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk); #1;
      if (cnt_re[1] >= 2) got = 1'b1;
    end
    chk("wait_two_reads", 1, 32'(got), 32'd1);
    reset = 1'b0;
    #1 chk_async_zero();
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    clr_cnt();
    repeat (5) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("post_rst_dones", d, 32'(cnt_done[d]), 32'd0);
      chk("post_rst_reads", d, 32'(cnt_re[d]), 32'd0);
    end
    clr_cnt();
    pulse_start(13'h0600, 13'd2);
    wait_idle(200);
    for (int d = 0; d < 2; d++) begin
      chk("restart_reads", d, 32'(cnt_re[d]), 32'd2);
      chk("restart_dones", d, 32'(cnt_done[d]), 32'd1);
      chk("restart_last", d, 32'(raddr_o[d]), 32'h0601);
    end

    // Randomized runs with stray starts, checked cycle by cycle by the model
    for (int r = 0; r < 20; r++) begin
      pulse_start(AW'($urandom), AW'($urandom_range(0, 7)));
      for (int k = 0; k < 30; k++) begin
        @(posedge clk); #1;
        start     = ($urandom_range(0, 3) == 0);
        base_addr = AW'($urandom);
        num_tiles = AW'($urandom_range(0, 7));
      end
      start = 1'b0;
      wait_idle(300);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
